// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: shadow EX..WB destinations drive load-use/branch stalls,
// decode-redirect flush, and EX forwarding selects.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int BR_LAT   = 2,
  parameter int FW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_branch,
  input  logic              id_redirect,
  input  logic              ext_stall,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic [31:0]       stall_cnt
);

  logic [DEPTH:1]    e_valid;
  logic [DEPTH:1]    e_wr;
  logic [DEPTH:1]    e_ld;
  logic [REG_AW-1:0] e_rd [1:DEPTH];
  logic [REG_AW-1:0] e_rs1;
  logic [REG_AW-1:0] e_rs2;

  logic load_use;
  logic br_dep;
  logic hz_stall;

  always_comb begin
    logic hit1;
    logic hit2;
    hit1     = 1'b0;
    hit2     = 1'b0;
    load_use = 1'b0;
    br_dep   = 1'b0;
    for (int j = 1; j <= DEPTH; j++) begin
      hit1 = e_valid[j] && e_wr[j] && id_use1 && (id_rs1 != '0) && (e_rd[j] == id_rs1);
      hit2 = e_valid[j] && e_wr[j] && id_use2 && (id_rs2 != '0) && (e_rd[j] == id_rs2);
      if ((j <= LOAD_LAT) && e_ld[j] && (hit1 || hit2)) load_use = 1'b1;
      if ((j <= BR_LAT) && (hit1 || hit2))             br_dep   = 1'b1;
    end
    load_use = load_use && id_valid;
    br_dep   = br_dep && id_valid && id_branch;
  end

  assign hz_stall = load_use | br_dep;

  // ext_stall freezes everything; otherwise a hazard bubbles EX and suppresses redirect
  always_comb begin
    pc_en       = !ext_stall && !hz_stall;
    ifid_en     = !ext_stall && !hz_stall;
    idex_bubble = !ext_stall && hz_stall;
    ifid_flush  = !ext_stall && !hz_stall && id_valid && id_redirect;
  end

  // Iterate oldest to youngest so the nearest producer overwrites older ones
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH; k >= 2; k--) begin
      if (e_valid[1] && e_valid[k] && e_wr[k]) begin
        if ((e_rs1 != '0) && (e_rd[k] == e_rs1)) fwd_a = FW'(k - 1);
        if ((e_rs2 != '0) && (e_rd[k] == e_rs2)) fwd_b = FW'(k - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid <= '0;
    end else if (!ext_stall) begin
      for (int k = 2; k <= DEPTH; k++) begin
        e_valid[k] <= e_valid[k-1];
        e_wr[k]    <= e_wr[k-1];
        e_ld[k]    <= e_ld[k-1];
        e_rd[k]    <= e_rd[k-1];
      end
      e_valid[1] <= id_valid && !hz_stall;
      e_wr[1]    <= id_reg_write && !hz_stall;
      e_ld[1]    <= id_mem_read && !hz_stall;
      e_rd[1]    <= id_rd;
      e_rs1      <= id_rs1;
      e_rs2      <= id_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
